// File: rtl/conv_window_feeder.sv
// Raster-order pixel stream to 3x3 window converter for the conv datapath.
// Two line buffers per channel feed a column-shifting window; valid-padding only.
module conv_window_feeder #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int DW    = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3*DW-1:0]   i_pixel,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [9*DW-1:0]   o_busData0,
    output logic [9*DW-1:0]   o_busData1,
    output logic [9*DW-1:0]   o_busData2,
    output logic              o_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [8:0][DW-1:0]     win_q [3];
    logic [8:0][DW-1:0]     win_d [3];
    logic [DW-1:0]          line_a_q [3][IMG_W];
    logic [DW-1:0]          line_b_q [3][IMG_W];

    logic accept_s;
    logic consume_s;
    logic emit_s;
    logic final_px_s;

    assign o_ready    = ~valid_q | i_ready;
    assign accept_s   = i_valid & o_ready;
    assign consume_s  = valid_q & i_ready;
    assign final_px_s = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign emit_s     = accept_s && (row_q >= RW'(2)) && (col_q >= CW'(2));

    // Raster position: col wraps into row, row wraps into the next frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept_s) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q == RW'(IMG_H - 1)) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Window shift: element 8 is the newest pixel, column 2 is the right-hand column.
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            win_d[ch] = win_q[ch];
            if (accept_s) begin
                win_d[ch] = {i_pixel[ch*DW +: DW], win_q[ch][8], win_q[ch][7],
                             line_a_q[ch][col_q],  win_q[ch][5], win_q[ch][4],
                             line_b_q[ch][col_q],  win_q[ch][2], win_q[ch][1]};
            end else begin
                win_d[ch] = win_q[ch];
            end
        end
    end

    // Output valid/last: a new window wins over a simultaneous consume.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        if (emit_s) begin
            valid_d = 1'b1;
            last_d  = final_px_s;
        end else if (consume_s) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            valid_d = valid_q;
            last_d  = last_q;
        end
    end

    // Control and window state with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                win_q[ch] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            for (int ch = 0; ch < 3; ch++) begin
                win_q[ch] <= win_d[ch];
            end
        end
    end

    // Line buffers: contents are always rewritten before they can reach a valid window.
    always_ff @(posedge i_clk) begin
        if (accept_s) begin
            for (int ch = 0; ch < 3; ch++) begin
                line_b_q[ch][col_q] <= line_a_q[ch][col_q];
                line_a_q[ch][col_q] <= i_pixel[ch*DW +: DW];
            end
        end
    end

    assign o_valid    = valid_q;
    assign o_last     = last_q;
    assign o_busData0 = win_q[0];
    assign o_busData1 = win_q[1];
    assign o_busData2 = win_q[2];

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder (4x4 image): a frame-level reference
// model builds the expected window list and pixel positions from raster arithmetic.
module tb_conv_window_feeder;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct {
        logic [89:0] b0;
        logic [89:0] b1;
        logic [89:0] b2;
        logic        last;
    } win_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [29:0] i_pixel;
    logic        o_valid;
    logic        i_ready;
    logic [89:0] o_busData0;
    logic [89:0] o_busData1;
    logic [89:0] o_busData2;
    logic        o_last;

    logic [29:0] in_q [$];
    win_t        exp_q [$];
    int          idx;
    int          n_cmp;
    int          n_bad;

    conv_window_feeder #(.IMG_W(W), .IMG_H(H), .DW(10)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_pixel    (i_pixel),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_busData0 (o_busData0),
        .o_busData1 (o_busData1),
        .o_busData2 (o_busData2),
        .o_last     (o_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ch0 = row*W+col, ch1 = ch0+100, ch2 = ch0+200; mode 1: random pixels
    task automatic load_frame(input int mode, input int nfr);
        logic [9:0] img [3][H][W];
        win_t e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (mode == 0) begin
                    img[0][r][c] = 10'(r * W + c);
                    img[1][r][c] = 10'(r * W + c + 100);
                    img[2][r][c] = 10'(r * W + c + 200);
                end else begin
                    for (int ch = 0; ch < 3; ch++) img[ch][r][c] = 10'($urandom_range(0, 1023));
                end
            end
        end
        for (int f = 0; f < nfr; f++) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    in_q.push_back({img[2][r][c], img[1][r][c], img[0][r][c]});
            for (int r = 2; r < H; r++) begin
                for (int c = 2; c < W; c++) begin
                    for (int k = 0; k < 9; k++) begin
                        e.b0[10*k +: 10] = img[0][r-2+k/3][c-2+k%3];
                        e.b1[10*k +: 10] = img[1][r-2+k/3][c-2+k%3];
                        e.b2[10*k +: 10] = img[2][r-2+k/3][c-2+k%3];
                    end
                    e.last = (r == H - 1) && (c == W - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // One clock: drive, check handshakes/window data, advance, check valid timing.
    task automatic step(input bit v, input bit rdy);
        bit          emit_nxt;
        bit          held;
        logic [89:0] hb0;
        win_t        e;
        int          r;
        int          c;
        emit_nxt = 1'b0;
        held     = 1'b0;
        hb0      = '0;
        i_valid  = v && (in_q.size() > 0);
        i_pixel  = (in_q.size() > 0) ? in_q[0] : 30'd0;
        i_ready  = rdy;
        #1;
        chk("ready_rule", 96'(o_ready), 96'(!o_valid || rdy));
        if (o_valid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("extra_window", 96'(o_valid), 96'(0));
            end else begin
                e = exp_q.pop_front();
                chk("bus0", 96'(o_busData0), 96'(e.b0));
                chk("bus1", 96'(o_busData1), 96'(e.b1));
                chk("bus2", 96'(o_busData2), 96'(e.b2));
                chk("last", 96'(o_last), 96'(e.last));
            end
        end else if (o_valid) begin
            held = 1'b1;
            hb0  = o_busData0;
        end
        if (i_valid && o_ready) begin
            r = (idx / W) % H;
            c = idx % W;
            emit_nxt = (r >= 2) && (c >= 2);
            idx++;
            void'(in_q.pop_front());
        end
        @(posedge i_clk);
        #1;
        if (emit_nxt) begin
            chk("valid_latency", 96'(o_valid), 96'(1));
        end else if (held) begin
            chk("hold_valid", 96'(o_valid), 96'(1));
            chk("hold_bus0", 96'(o_busData0), 96'(hb0));
        end else begin
            chk("valid_clear", 96'(o_valid), 96'(0));
        end
    endtask

    task automatic drain(input bit rand_v, input bit rand_r);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < 600) begin
            step(rand_v ? 1'($urandom % 2) : 1'b1, rand_r ? 1'($urandom % 2) : 1'b1);
            n++;
        end
        chk("drain_done", 96'(in_q.size() + exp_q.size()), 96'(0));
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    initial begin
        int sz;
        int n;
        n_cmp   = 0;
        n_bad   = 0;
        idx     = 0;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_pixel = '0;
        #12;
        chk("rst_valid", 96'(o_valid), 96'(0));
        chk("rst_last", 96'(o_last), 96'(0));
        chk("rst_bus0", 96'(o_busData0), 96'(0));
        chk("rst_bus2", 96'(o_busData2), 96'(0));
        chk("rst_ready", 96'(o_ready), 96'(1));
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Gap-free directed frame
        load_frame(0, 1);
        drain(1'b0, 1'b0);

        // Stall on the first window: pixel 11 must wait
        load_frame(0, 1);
        n = 0;
        while (!o_valid && n < 40) begin
            step(1'b1, 1'b1);
            n++;
        end
        chk("stall_first_valid", 96'(o_valid), 96'(1));
        sz = in_q.size();
        repeat (6) step(1'b1, 1'b0);
        chk("stall_not_taken", 96'(in_q.size()), 96'(sz));
        chk("stall_next_pixel", 96'(in_q[0][9:0]), 96'(11));
        drain(1'b0, 1'b0);

        // Two random frames back to back
        load_frame(1, 2);
        drain(1'b0, 1'b0);

        // Random input gaps, then random gaps on both sides
        load_frame(0, 1);
        drain(1'b1, 1'b0);
        load_frame(1, 2);
        drain(1'b1, 1'b1);

        // Asynchronous reset after pixel 6
        load_frame(1, 1);
        n = 0;
        while (idx % (W * H) < 7 && n < 40) begin
            step(1'b1, 1'b1);
            n++;
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 96'(o_valid), 96'(0));
        chk("arst_last", 96'(o_last), 96'(0));
        chk("arst_bus1", 96'(o_busData1), 96'(0));
        in_q.delete();
        exp_q.delete();
        idx = 0;
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        load_frame(0, 1);
        drain(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
